// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction memory fetch block.
package imem_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned IMEM_DEPTH = 64;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               fault;
    } fetch_rsp_t;

endpackage

// File: rtl/imem_array.sv
// Word storage with one synchronous read port and one write port.
// The read data register is cleared by reset; the array contents are not.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned  DATA_W = INSTR_W,
    parameter int unsigned  DEPTH  = IMEM_DEPTH,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Sampling mem_q on the same edge as the write gives read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with valid/ready fetch, program-load port and fetch counter.
// Define IMEM_FAULT_EN to flag misaligned / out-of-range requests as faults.
module instr_mem_fetch
    import imem_pkg::*;
#(
    parameter int unsigned  DATA_W = INSTR_W,
    parameter int unsigned  DEPTH  = IMEM_DEPTH,
    parameter int unsigned  ADDR_W = 64,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_fault,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    output logic [31:0]       fetch_cnt
);

    logic              rsp_valid_q, rsp_valid_d;
    logic              fault_q, fault_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              req_fire;
    logic              rsp_fire;
    logic              req_fault;
    logic              rd_en;
    logic [IDX_W-1:0]  req_idx;
    logic [DATA_W-1:0] rd_data;

    assign req_idx = req_addr[IDX_W+1:2];

`ifdef IMEM_FAULT_EN
    assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:IDX_W+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
    assign req_fault        = 1'b0;
`endif

    // Held off during reset so nothing looks accepted while state is forced clear.
    assign req_ready = !reset && (!rsp_valid_q || rsp_ready);
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid_q && rsp_ready;
    assign rd_en     = req_fire && !req_fault;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        if (req_fire) begin
            rsp_valid_d = 1'b1;
            fault_d     = req_fault;
        end else if (rsp_fire) begin
            rsp_valid_d = 1'b0;
        end
        if (rsp_fire) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    // A faulting request skips the read, so the held read data is masked instead.
    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_en_i   (rd_en),
        .rd_idx_i  (req_idx),
        .rd_data_o (rd_data),
        .wr_en_i   (ld_en),
        .wr_idx_i  (ld_idx),
        .wr_data_i (ld_data)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = fault_q;
    assign rsp_instr = fault_q ? '0 : rd_data;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch; expectations follow IMEM_FAULT_EN when defined.
module tb_instr_mem_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_fault;
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [31:0] ld_data;
    logic [31:0] fetch_cnt;

    int checks   = 0;
    int failures = 0;

    instr_mem_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_idx  = idx;
        ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    initial begin
        int sent;
        int got;
        logic do_req;
        logic do_rsp;
        logic        exp_fault;
        logic [31:0] exp_wrap;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;
        ld_idx    = '0;
        ld_data   = '0;
        #3;
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_instr", rsp_instr, 0);
        check_eq("rst_fault", rsp_fault, 0);
        check_eq("rst_cnt", fetch_cnt, 0);
        #9 reset = 1'b0;
        tick();

        load(6'd1, 32'h8B020020);
        load(6'd2, 32'hCB030041);
        load(6'd3, 32'hAAAAAAAA);

        // Back-to-back fetches
        req_valid = 1'b1;
        req_addr  = 64'h4;
        rsp_ready = 1'b1;
        tick();
        req_addr = 64'h8;
        #1;
        check_eq("b2b_valid0", rsp_valid, 1);
        check_eq("b2b_instr0", rsp_instr, 32'h8B020020);
        tick();
        req_valid = 1'b0;
        #1;
        check_eq("b2b_valid1", rsp_valid, 1);
        check_eq("b2b_instr1", rsp_instr, 32'hCB030041);
        tick();
        check_eq("b2b_cnt", fetch_cnt, 2);
        check_eq("b2b_idle", rsp_valid, 0);
        check_eq("b2b_hold", rsp_instr, 32'hCB030041);

        // Stall for 3 cycles, with a load to the same word and a pending request
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 64'h4;
        tick();
        req_addr = 64'h8;
        ld_en    = 1'b1;
        ld_idx   = 6'd1;
        ld_data  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_valid", rsp_valid, 1);
            check_eq("stall_instr", rsp_instr, 32'h8B020020);
            check_eq("stall_ready", req_ready, 0);
            tick();
            ld_en = 1'b0;
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        #1;
        check_eq("stall_release_ready", req_ready, 1);
        tick();
        check_eq("stall_cnt", fetch_cnt, 3);
        check_eq("stall_done", rsp_valid, 0);
        load(6'd1, 32'h8B020020);

        // Load and fetch of the same word in one cycle
        ld_en     = 1'b1;
        ld_idx    = 6'd3;
        ld_data   = 32'h12345678;
        req_valid = 1'b1;
        req_addr  = 64'hC;
        tick();
        ld_en = 1'b0;
        #1;
        check_eq("rbw_old", rsp_instr, 32'hAAAAAAAA);
        tick();
        req_valid = 1'b0;
        #1;
        check_eq("rbw_new", rsp_instr, 32'h12345678);
        tick();
        check_eq("rbw_cnt", fetch_cnt, 5);

        // Out-of-range then misaligned address
`ifdef IMEM_FAULT_EN
        exp_fault = 1'b1;
        exp_wrap  = 32'h0;
`else
        exp_fault = 1'b0;
        exp_wrap  = 32'h8B020020;
`endif
        req_valid = 1'b1;
        req_addr  = 64'h104;
        tick();
        req_addr = 64'h6;
        #1;
        check_eq("oor_fault", rsp_fault, exp_fault);
        check_eq("oor_instr", rsp_instr, exp_wrap);
        tick();
        req_valid = 1'b0;
        #1;
        check_eq("mis_fault", rsp_fault, exp_fault);
        check_eq("mis_instr", rsp_instr, exp_wrap);
        tick();
        check_eq("fault_cnt", fetch_cnt, 7);

        // Reset while a response is held
        req_valid = 1'b1;
        req_addr  = 64'h8;
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        #1;
        check_eq("pre_rst_valid", rsp_valid, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_valid", rsp_valid, 0);
        check_eq("async_rst_cnt", fetch_cnt, 0);
        check_eq("async_rst_instr", rsp_instr, 0);
        req_valid = 1'b1;
        req_addr  = 64'h4;
        rsp_ready = 1'b1;
        tick();
        check_eq("in_rst_valid", rsp_valid, 0);
        check_eq("in_rst_ready", req_ready, 0);
        #1 reset = 1'b0;
        tick();
        req_valid = 1'b0;
        #1;
        check_eq("post_rst_valid", rsp_valid, 1);
        check_eq("post_rst_instr", rsp_instr, 32'h8B020020);
        tick();
        check_eq("post_rst_cnt", fetch_cnt, 1);

        // Streamed requests with toggling backpressure
        for (int i = 0; i < 10; i++) begin
            load(6'(4 + i), 32'h10000000 + 32'(i));
        end
        reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        sent      = 0;
        got       = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'(16);
        for (int c = 0; c < 60 && got < 10; c++) begin
            #1;
            do_req = req_valid && req_ready;
            do_rsp = rsp_valid && rsp_ready;
            if (do_rsp) begin
                check_eq("stream_instr", rsp_instr, 64'(32'h10000000 + 32'(got)));
                got++;
            end
            tick();
            if (do_req) sent++;
            req_valid = (sent < 10);
            req_addr  = 64'((4 + sent) * 4);
            rsp_ready = ~rsp_ready;
        end
        check_eq("stream_count", 64'(got), 10);
        check_eq("stream_cnt", fetch_cnt, 10);
        req_valid = 1'b0;
        tick();
        check_eq("stream_drained", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
